mic1_microsequencer: RTL and testbench

- Upstream control stage of the MIC-1 datapath: holds the 512x36 control store, the MPC (microprogram counter) and the MIR (microinstruction register).
- Computes the next microaddress from the NEXT_ADDRESS, JMPC, JAMN and JAMZ fields, the ALU N/Z flags and MBR.
- Drives the 4-bit B-bus select field into the B-bus 4x16 decoder, plus the ALU, shifter, C-bus enable and memory strobes.
- Stalls on an outstanding memory operation; supports halt and control-store loading.

---
 rtl/mic1_microsequencer.sv | 146 ++++++++++++++
 tb/tb_mic1_microsequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_microsequencer.sv
// -----------------------------------------------------------------------------
// mic1_microsequencer
//
// Upstream control stage of the MIC-1 datapath. It holds the 512x36 control
// store, the microprogram counter (MPC) and the microinstruction register
// (MIR). It computes the next microaddress from NEXT_ADDRESS / JMPC / JAMN /
// JAMZ, the ALU flags and MBR, and stalls while a memory operation is pending.
//
// MIR field map (MSB..LSB):
//   [35:27] NEXT_ADDRESS  [26] JMPC  [25] JAMN  [24] JAMZ
//   [23] SLL8  [22] SRA1  [21:16] F0,F1,ENA,ENB,INVA,INC
//   [15:7] C   [6] WRITE  [5] READ  [4] FETCH  [3:0] B
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      pulse: leave IDLE/HALT and execute from address 0
//   cs_we, cs_addr, cs_wdata   control-store write port (IDLE/HALT only)
//   alu_n, alu_z               ALU flags of the current microinstruction
//   mbr                        MBR contents, ORed into the address by JMPC
//   mem_ack                    memory completes the pending operation this cycle
//   b_sel, alu_ctl, sh_ctl     MIR B / ALU / shifter fields
//   c_en                       C-bus load enables, only in a retiring cycle
//   mem_write/read/fetch       memory strobes, only while executing
//   mpc_out                    current MPC
//   busy, halted               status (RUN or WAIT / HALT)
// -----------------------------------------------------------------------------
module mic1_microsequencer #(
    parameter int                ADDR_W    = 9,
    parameter int                WORD_W    = 36,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 9'h1FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cs_we,
    input  logic [ADDR_W-1:0] cs_addr,
    input  logic [WORD_W-1:0] cs_wdata,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [7:0]        mbr,
    input  logic              mem_ack,
    output logic [3:0]        b_sel,
    output logic [5:0]        alu_ctl,
    output logic [1:0]        sh_ctl,
    output logic [8:0]        c_en,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_fetch,
    output logic [ADDR_W-1:0] mpc_out,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   mpc;
    logic [WORD_W-1:0]   mir;
    logic [WORD_W-1:0]   cs [2**ADDR_W];

    logic [ADDR_W-1:0]   next_field;
    logic                jmpc, jamn, jamz;
    logic [2:0]          mem_bits;
    logic                active;
    logic                retire;
    logic                halt_hit;
    logic [ADDR_W-1:0]   next_addr;

    assign next_field = mir[35:27];
    assign jmpc       = mir[26];
    assign jamn       = mir[25];
    assign jamz       = mir[24];
    assign mem_bits   = mir[6:4];

    assign active   = (state == RUN) || (state == WAIT);
    // In WAIT the memory bits are necessarily set, so mem_ack alone retires.
    assign retire   = active && ((mem_bits == 3'b000) || mem_ack);
    assign halt_hit = (next_field == HALT_ADDR) && !jmpc && !jamn && !jamz;

    // NOTE: every output of a combinational block gets a default assignment
    // first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        next_addr = next_field;
        if (jmpc) begin
            next_addr[7:0] = next_field[7:0] | mbr;
        end
        next_addr[ADDR_W-1] = next_field[ADDR_W-1] | (jamn & alu_n) | (jamz & alu_z);
    end

    // NOTE: the control store is a plain RAM with no reset; its contents are
    // only ever defined by explicit writes, which keeps it mappable to memory.
    always_ff @(posedge clk) begin
        if (cs_we && !active) begin
            cs[cs_addr] <= cs_wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mpc   <= '0;
            mir   <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    // A simultaneous write takes priority over start.
                    if (start && !cs_we) begin
                        state <= RUN;
                        mpc   <= '0;
                        mir   <= cs[0];
                    end
                end
                RUN, WAIT: begin
                    if (retire) begin
                        if (halt_hit) begin
                            state <= HALT;
                            mpc   <= HALT_ADDR;
                            mir   <= '0;
                        end else begin
                            state <= RUN;
                            mpc   <= next_addr;
                            mir   <= cs[next_addr];
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign b_sel     = mir[3:0];
    assign alu_ctl   = mir[21:16];
    assign sh_ctl    = mir[23:22];
    assign c_en      = retire ? mir[15:7] : 9'd0;
    assign mem_write = active & mir[6];
    assign mem_read  = active & mir[5];
    assign mem_fetch = active & mir[4];
    assign mpc_out   = mpc;
    assign busy      = active;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_mic1_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_mic1_microsequencer
//
// Directed bench for mic1_microsequencer. A behavioural model tracks the
// control-store contents, whether an instruction is executing, the current
// address and the current microinstruction word; expected outputs are derived
// from it every falling edge. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_mic1_microsequencer;

    localparam logic [35:0] HALT_WORD = {9'h1FF, 27'd0};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cs_we;
    logic [8:0]  cs_addr;
    logic [35:0] cs_wdata;
    logic        alu_n;
    logic        alu_z;
    logic [7:0]  mbr;
    logic        mem_ack;
    logic [3:0]  b_sel;
    logic [5:0]  alu_ctl;
    logic [1:0]  sh_ctl;
    logic [8:0]  c_en;
    logic        mem_write;
    logic        mem_read;
    logic        mem_fetch;
    logic [8:0]  mpc_out;
    logic        busy;
    logic        halted;

    mic1_microsequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cs_we     (cs_we),
        .cs_addr   (cs_addr),
        .cs_wdata  (cs_wdata),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .mbr       (mbr),
        .mem_ack   (mem_ack),
        .b_sel     (b_sel),
        .alu_ctl   (alu_ctl),
        .sh_ctl    (sh_ctl),
        .c_en      (c_en),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_fetch (mem_fetch),
        .mpc_out   (mpc_out),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {NEXT, {JMPC,JAMN,JAMZ}, {SLL8,SRA1}, ALU, C, {WRITE,READ,FETCH}, B}
    function automatic logic [35:0] mk(input logic [8:0] na, input logic [2:0] j,
                                       input logic [1:0] sh, input logic [5:0] alu,
                                       input logic [8:0] c, input logic [2:0] mem,
                                       input logic [3:0] b);
        return {na, j, sh, alu, c, mem, b};
    endfunction

    // ---------------- behavioural model ----------------
    logic [35:0] m_cs [512];
    bit          m_exec   = 1'b0;
    bit          m_halted = 1'b0;
    logic [8:0]  m_pc     = 9'd0;
    logic [35:0] m_word   = 36'd0;

    function automatic logic [8:0] model_next(input logic [35:0] w, input logic [7:0] m,
                                              input logic n, input logic z);
        int a;
        a = int'(w[35:27]);
        if (w[26]) a = a | int'(m);
        if ((w[25] && n) || (w[24] && z)) a = a | 256;
        return 9'(a);
    endfunction

    function automatic bit model_halts(input logic [35:0] w);
        return (w[35:27] == 9'h1FF) && (w[26:24] == 3'b000);
    endfunction

    function automatic bit model_done(input logic [35:0] w, input logic ack);
        return (w[6:4] == 3'b000) || ack;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exec   <= 1'b0;
            m_halted <= 1'b0;
            m_pc     <= 9'd0;
            m_word   <= 36'd0;
        end else if (!m_exec) begin
            if (cs_we) begin
                m_cs[cs_addr] <= cs_wdata;
            end else if (start) begin
                m_exec   <= 1'b1;
                m_halted <= 1'b0;
                m_pc     <= 9'd0;
                m_word   <= m_cs[0];
            end
        end else if (model_done(m_word, mem_ack)) begin
            if (model_halts(m_word)) begin
                m_exec   <= 1'b0;
                m_halted <= 1'b1;
                m_pc     <= 9'h1FF;
                m_word   <= 36'd0;
            end else begin
                m_pc   <= model_next(m_word, mbr, alu_n, alu_z);
                m_word <= m_cs[model_next(m_word, mbr, alu_n, alu_z)];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("fields", {b_sel, alu_ctl, sh_ctl},
                  {m_word[3:0], m_word[21:16], m_word[23:22]});
            check("c_en", c_en,
                  (m_exec && model_done(m_word, mem_ack)) ? m_word[15:7] : 9'd0);
            check("strobes", {mem_write, mem_read, mem_fetch},
                  m_exec ? m_word[6:4] : 3'b000);
            check("status", {mpc_out, busy, halted}, {m_pc, m_exec, m_halted});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [35:0] d);
        cs_we    = 1'b1;
        cs_addr  = a;
        cs_wdata = d;
        tick();
        cs_we    = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cs_we = 1'b0; cs_addr = '0; cs_wdata = '0;
        alu_n = 1'b0; alu_z = 1'b0; mbr = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_status", {mpc_out, busy, halted}, 11'd0);
        check("reset_outs", {b_sel, alu_ctl, sh_ctl, c_en, mem_write, mem_read, mem_fetch}, 0);
        tick();
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        for (int i = 0; i < 512; i++) wr(9'(i), HALT_WORD);

        // Straight-line program: 0 -> 1 -> halt
        wr(9'h000, mk(9'h001, 3'b000, 2'b10, 6'h3C, 9'h001, 3'b000, 4'h2));
        go();
        @(negedge clk);
        check("t1_b_sel", b_sel, 4'h2);
        check("t1_c_en", c_en, 9'h001);
        check("t1_mpc0", mpc_out, 9'h000);
        check("t1_alu_sh", {alu_ctl, sh_ctl}, {6'h3C, 2'b10});
        tick(); @(negedge clk);
        check("t1_mpc1", mpc_out, 9'h001);
        tick(); @(negedge clk);
        check("t1_halted", {halted, busy, mem_write, mem_read, mem_fetch, c_en}, {1'b1, 13'd0});
        check("t1_halt_mpc", mpc_out, 9'h1FF);

        // JAMZ taken / not taken, JAMN taken
        wr(9'h000, mk(9'h005, 3'b001, 2'b00, 6'h00, 9'h000, 3'b000, 4'h0));
        alu_z = 1'b1; go(); tick(); @(negedge clk);
        check("jamz_taken", mpc_out, 9'h105);
        tick();
        alu_z = 1'b0; go(); tick(); @(negedge clk);
        check("jamz_not_taken", mpc_out, 9'h005);
        tick();
        wr(9'h000, mk(9'h005, 3'b010, 2'b00, 6'h00, 9'h000, 3'b000, 4'h0));
        alu_n = 1'b1; go(); tick(); @(negedge clk);
        check("jamn_taken", mpc_out, 9'h105);
        tick(); alu_n = 1'b0;

        // JMPC
        wr(9'h000, mk(9'h000, 3'b100, 2'b00, 6'h00, 9'h000, 3'b000, 4'h0));
        mbr = 8'h10; go(); tick(); @(negedge clk);
        check("jmpc_mbr10", mpc_out, 9'h010);
        tick();
        wr(9'h000, mk(9'h100, 3'b100, 2'b00, 6'h00, 9'h000, 3'b000, 4'h0));
        mbr = 8'hFF; go(); tick(); @(negedge clk);
        check("jmpc_1ff", {mpc_out, busy, halted}, {9'h1FF, 1'b1, 1'b0});
        tick(); @(negedge clk);
        check("jmpc_then_halt", halted, 1'b1);
        mbr = 8'h00;

        // Memory stall with JAMZ: flags only count in the ack cycle
        wr(9'h000, mk(9'h002, 3'b001, 2'b00, 6'h00, 9'h010, 3'b010, 4'h0));
        mem_ack = 1'b0; alu_z = 1'b1; go();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_cycle", {mem_read, c_en, mpc_out}, {1'b1, 9'h000, 9'h000});
            tick();
        end
        mem_ack = 1'b1; alu_z = 1'b0;
        @(negedge clk);
        check("stall_ack", {mem_read, c_en, mpc_out}, {1'b1, 9'h010, 9'h000});
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check("stall_after", {mem_read, mpc_out}, {1'b0, 9'h002});
        tick();

        // Writes during RUN are ignored
        wr(9'h000, mk(9'h001, 3'b000, 2'b00, 6'h00, 9'h000, 3'b000, 4'h7));
        go();
        cs_we = 1'b1; cs_addr = 9'h000; cs_wdata = mk(9'h001, 3'b000, 2'b00, 6'h00, 9'h000, 3'b000, 4'hA);
        tick(); cs_we = 1'b0;
        tick();
        go(); @(negedge clk);
        check("cs_protect", b_sel, 4'h7);
        tick(); tick();

        // start together with cs_we in IDLE: write only
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        cs_we = 1'b1; start = 1'b1; cs_addr = 9'h000;
        cs_wdata = mk(9'h001, 3'b000, 2'b00, 6'h00, 9'h000, 3'b000, 4'hC);
        tick(); cs_we = 1'b0; start = 1'b0;
        @(negedge clk);
        check("start_we_idle", {busy, halted, b_sel}, 6'd0);
        go(); @(negedge clk);
        check("start_we_written", b_sel, 4'hC);
        tick(); tick();

        // Asynchronous reset while waiting on memory
        wr(9'h000, mk(9'h002, 3'b000, 2'b00, 6'h00, 9'h000, 3'b010, 4'h0));
        mem_ack = 1'b0; go(); tick();
        check("pre_reset_wait", {mem_read, busy}, 2'b11);
        rst_n = 1'b0; #1;
        check("async_reset", {mem_read, busy, c_en}, 11'd0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", {busy, halted, mpc_out}, 11'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
